even_issue_scoreboard: RTL and testbench

- Issue-side hazard scoreboard and sequencer for the even execution pipe (FX1/FX2/SP/BYTE units, 7-stage result shift chain with forwarding taps at stages 2–7).
- Mirrors every in-flight even-pipe instruction, including its destination, latency and current stage.
- Stalls issue when a source register depends on a producer whose result is not yet forwardable.
- Tracks flush kills identically to the pipe, supports a drain handshake, and counts stall cycles.

---
 rtl/even_issue_scoreboard.sv | 181 ++++++++++++++++++
 tb/tb_even_issue_scoreboard.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/even_issue_scoreboard.sv
// even_issue_scoreboard
//   Issue-side hazard scoreboard for the even execution pipe (FX1/FX2/SP/BYTE).
//   Mirrors the pipe's 7-stage result shift chain: slot k holds the
//   instruction at pipe stage k+1 (stages 2..7). A source read stalls issue
//   while its youngest in-flight producer has not reached its result-ready
//   stage. Flush kills follow the pipe exactly. A drain handshake quiesces
//   the pipe, and a saturating counter records stall cycles.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   issue_valid              decode presents an even-pipe instruction
//   issue_reg_dst/_wr        destination register and write enable
//   issue_latency            result-ready stage (clamped to 2..7 on entry)
//   ra/rb/rc_addr, _use      source addresses and their read enables
//   flush, flush_4stage      branch flush; optionally also kills stage 4
//   drain_req                request to quiesce the pipe
//   issue_ready (comb)       instruction may issue this cycle
//   issue_fire  (comb)       issue_valid & issue_ready
//   stall_raw   (comb)       RAW hazard on any used source
//   drained     (reg)        pipe empty and held in the drained state
//   inflight_count (reg)     number of valid slots
//   stall_cycles   (reg)     saturating count of stalled issue cycles
module even_issue_scoreboard #(
  parameter int NSLOT  = 6,
  parameter int REG_AW = 7,
  parameter int LAT_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_valid,
  input  logic [REG_AW-1:0]              issue_reg_dst,
  input  logic                           issue_reg_wr,
  input  logic [LAT_W-1:0]               issue_latency,
  input  logic [REG_AW-1:0]              ra_addr,
  input  logic [REG_AW-1:0]              rb_addr,
  input  logic [REG_AW-1:0]              rc_addr,
  input  logic                           ra_use,
  input  logic                           rb_use,
  input  logic                           rc_use,
  input  logic                           flush,
  input  logic                           flush_4stage,
  input  logic                           drain_req,
  output logic                           issue_ready,
  output logic                           issue_fire,
  output logic                           stall_raw,
  output logic                           drained,
  output logic [$clog2(NSLOT+1)-1:0]     inflight_count,
  output logic [CNT_W-1:0]               stall_cycles
);

  localparam int CW = $clog2(NSLOT + 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] reg_dst;
    logic              reg_wr;
    logic [LAT_W-1:0]  latency;
  } slot_t;

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  slot_t             slot_q [1:NSLOT];
  slot_t             slot_d [1:NSLOT];
  state_t            state;
  logic [LAT_W-1:0]  lat_clamped;
  logic [2:0]        src_use;
  logic [2:0][REG_AW-1:0] src_addr;
  logic [2:0]        src_hit;
  logic [CW-1:0]     next_count;
  logic              next_empty;
  logic              stall_count_en;

  assign src_use  = {rc_use, rb_use, ra_use};
  assign src_addr = {rc_addr, rb_addr, ra_addr};

  // Results are produced no earlier than stage 2 and are always forwardable
  // by stage 7, so out-of-range latencies are pulled into that window.
  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    lat_clamped = issue_latency;
    if (issue_latency < LAT_W'(2))
      lat_clamped = LAT_W'(2);
    else if (issue_latency > LAT_W'(7))
      lat_clamped = LAT_W'(7);
  end

  // Hazard search. Slots are scanned oldest to youngest so the youngest
  // matching producer writes the verdict last and overrides older matches.
  // A producer at stage k+1 is forwardable once k+1 >= its latency.
  always_comb begin
    src_hit = '0;
    for (int s = 0; s < 3; s++) begin
      for (int k = NSLOT; k >= 1; k--) begin
        if (src_use[s] && slot_q[k].valid && slot_q[k].reg_wr &&
            slot_q[k].reg_dst == src_addr[s])
          src_hit[s] = (LAT_W'(k + 1) < slot_q[k].latency);
      end
    end
  end

  assign stall_raw      = |src_hit;
  assign issue_ready    = ~stall_raw & ~flush & (state == RUN);
  assign issue_fire     = issue_valid & issue_ready;
  assign stall_count_en = issue_valid & ~issue_ready & (state == RUN) & ~flush;

  // Next slot contents: a plain shift, with the flush killing what would
  // land in stages 2 and 3 (and stage 4 as well when flush_4stage is set).
  // issue_ready is already low during a flush, so slot 1 stays empty then.
  always_comb begin
    slot_d[1] = '0;
    if (issue_fire) begin
      slot_d[1].valid   = 1'b1;
      slot_d[1].reg_dst = issue_reg_dst;
      slot_d[1].reg_wr  = issue_reg_wr;
      slot_d[1].latency = lat_clamped;
    end
    for (int k = 2; k <= NSLOT; k++)
      slot_d[k] = slot_q[k-1];
    if (flush) begin
      slot_d[2] = '0;
      if (flush_4stage)
        slot_d[3] = '0;
    end
  end

  always_comb begin
    next_count = '0;
    for (int k = 1; k <= NSLOT; k++)
      next_count = next_count + CW'(slot_d[k].valid);
  end

  assign next_empty = (next_count == '0);

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the slot array is small and fully cleared; only the valid bit
      // matters, but clearing the payload keeps stale X out of the mux tree.
      for (int k = 1; k <= NSLOT; k++)
        slot_q[k] <= '0;
      state          <= RUN;
      drained        <= 1'b0;
      inflight_count <= '0;
      stall_cycles   <= '0;
    end else begin
      slot_q         <= slot_d;
      inflight_count <= next_count;
      if (stall_count_en && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);

      unique case (state)
        RUN: begin
          if (drain_req)
            state <= DRAIN;
        end
        DRAIN: begin
          if (!drain_req) begin
            state <= RUN;
          end else if (next_empty) begin
            state   <= DRAINED;
            drained <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            state   <= RUN;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          drained <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_even_issue_scoreboard.sv
// Self-checking bench for even_issue_scoreboard. A queue-of-instructions
// model (each entry knows its current pipe stage) predicts every output on
// every cycle; directed scenarios add hand-computed stall counts and values.
module tb_even_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [6:0] issue_reg_dst;
  logic       issue_reg_wr;
  logic [3:0] issue_latency;
  logic [6:0] ra_addr, rb_addr, rc_addr;
  logic       ra_use, rb_use, rc_use;
  logic       flush, flush_4stage, drain_req;
  logic       issue_ready, issue_fire, stall_raw, drained;
  logic [2:0] inflight_count;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  even_issue_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_reg_dst (issue_reg_dst),
    .issue_reg_wr  (issue_reg_wr),
    .issue_latency (issue_latency),
    .ra_addr       (ra_addr),
    .rb_addr       (rb_addr),
    .rc_addr       (rc_addr),
    .ra_use        (ra_use),
    .rb_use        (rb_use),
    .rc_use        (rc_use),
    .flush         (flush),
    .flush_4stage  (flush_4stage),
    .drain_req     (drain_req),
    .issue_ready   (issue_ready),
    .issue_fire    (issue_fire),
    .stall_raw     (stall_raw),
    .drained       (drained),
    .inflight_count(inflight_count),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [6:0] dst;
    logic       wr;
    int         lat;
    int         stage;
  } m_entry_t;

  typedef enum {M_RUN, M_DRAIN, M_DRAINED} m_mode_t;

  m_entry_t m_q[$];
  m_mode_t  m_mode;
  bit       m_drained;
  int       m_count;
  longint   m_stall;
  bit       m_live = 1'b0;

  function automatic int clamp_lat(input logic [3:0] l);
    if (l < 2) return 2;
    if (l > 7) return 7;
    return int'(l);
  endfunction

  // Youngest producer = smallest stage; blocked while stage < latency.
  function automatic bit m_src_blocked(input logic use_i, input logic [6:0] addr);
    int best_stage = 0;
    int best_lat = 0;
    if (!use_i) return 1'b0;
    foreach (m_q[i])
      if (m_q[i].wr && m_q[i].dst == addr && (best_stage == 0 || m_q[i].stage < best_stage)) begin
        best_stage = m_q[i].stage;
        best_lat   = m_q[i].lat;
      end
    return (best_stage != 0) && (best_stage < best_lat);
  endfunction

  function automatic bit m_hazard();
    return m_src_blocked(ra_use, ra_addr) || m_src_blocked(rb_use, rb_addr) ||
           m_src_blocked(rc_use, rc_addr);
  endfunction

  function automatic bit m_ready();
    return !m_hazard() && !flush && m_mode == M_RUN;
  endfunction

  task automatic m_step();
    m_entry_t nq[$];
    m_entry_t e;
    bit fire;
    fire = issue_valid && m_ready();
    if (issue_valid && !m_ready() && m_mode == M_RUN && !flush && m_stall < 64'hFFFF_FFFF)
      m_stall++;
    foreach (m_q[i]) begin
      e = m_q[i];
      e.stage++;
      if (e.stage <= 7 && !(flush && (e.stage == 3 || (flush_4stage && e.stage == 4))))
        nq.push_back(e);
    end
    if (fire) begin
      e.dst = issue_reg_dst; e.wr = issue_reg_wr;
      e.lat = clamp_lat(issue_latency); e.stage = 2;
      nq.push_back(e);
    end
    m_q = nq;
    m_count = m_q.size();
    case (m_mode)
      M_RUN:     if (drain_req) m_mode = M_DRAIN;
      M_DRAIN:   if (!drain_req) m_mode = M_RUN;
                 else if (m_q.size() == 0) begin m_mode = M_DRAINED; m_drained = 1'b1; end
      M_DRAINED: if (!drain_req) begin m_mode = M_RUN; m_drained = 1'b0; end
      default:   m_mode = M_RUN;
    endcase
  endtask

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_q.delete();
      m_mode = M_RUN; m_drained = 1'b0; m_count = 0; m_stall = 0; m_live = 1'b1;
    end else if (m_live) begin
      m_step();
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("stall_raw",      stall_raw,      m_hazard());
      check("issue_ready",    issue_ready,    m_ready());
      check("issue_fire",     issue_fire,     issue_valid && m_ready());
      check("drained",        drained,        m_drained);
      check("inflight_count", inflight_count, m_count);
      check("stall_cycles",   stall_cycles,   m_stall);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 0; issue_reg_dst = 0; issue_reg_wr = 0; issue_latency = 2;
    ra_addr = 0; rb_addr = 0; rc_addr = 0; ra_use = 0; rb_use = 0; rc_use = 0;
    flush = 0; flush_4stage = 0; drain_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic [6:0] dst, input logic [3:0] lat, input logic wr = 1'b1);
    issue_valid = 1; issue_reg_dst = dst; issue_reg_wr = wr; issue_latency = lat;
    ra_use = 0; rb_use = 0; rc_use = 0;
    tick();
    issue_valid = 0;
  endtask

  // Present a non-writing consumer until it fires; src -1 = no source used.
  task automatic consume(input string name, input int src, input logic [6:0] addr,
                         input int exp_stalls);
    int stalls = 0;
    bit fired = 0;
    issue_reg_dst = 0; issue_reg_wr = 0; issue_latency = 2;
    ra_use = 0; rb_use = 0; rc_use = 0;
    ra_addr = addr; rb_addr = addr; rc_addr = addr;
    case (src)
      0: ra_use = 1;
      1: rb_use = 1;
      2: rc_use = 1;
      default: ;
    endcase
    issue_valid = 1;
    for (int i = 0; i < 16 && !fired; i++) begin
      @(negedge clk);
      if (issue_fire) fired = 1;
      else stalls++;
      tick();
    end
    issue_valid = 0; ra_use = 0; rb_use = 0; rc_use = 0;
    check({name, "_fired"}, fired, 1);
    check({name, "_stalls"}, stalls, exp_stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  done;
    clear_inputs();
    rst = 1;
    idle(2);
    @(negedge clk);
    check("reset_inflight", inflight_count, 0);
    check("reset_stall_cycles", stall_cycles, 0);
    check("reset_ready", issue_ready, 1);
    check("reset_drained", drained, 0);
    tick();
    rst = 0;

    // Long-latency RAW: producer L=6 blocks a consumer for 4 cycles.
    issue(7'd5, 4'd6);
    consume("long_raw", 0, 7'd5, 4);
    check("long_raw_count", stall_cycles, 4);
    idle(8);

    // Short latency: L=2 is forwardable from stage 2.
    issue(7'd3, 4'd2);
    consume("short", 1, 7'd3, 0);
    check("short_count", stall_cycles, 4);
    idle(8);

    // Youngest match: the L=7 producer governs, not the older L=2 one.
    issue(7'd9, 4'd2);
    issue(7'd9, 4'd7);
    consume("youngest", 2, 7'd9, 5);
    check("youngest_count", stall_cycles, 9);
    idle(8);

    // Latency clamps, unused sources (r0) and non-writing producers.
    issue(7'd10, 4'd0);
    consume("clamp_lo0", 0, 7'd10, 0);
    issue(7'd12, 4'd1);
    consume("clamp_lo1", 0, 7'd12, 0);
    issue(7'd11, 4'd15);
    consume("clamp_hi", 0, 7'd11, 5);
    idle(8);
    issue(7'd0, 4'd7);
    consume("unused_r0", -1, 7'd0, 0);
    issue(7'd13, 4'd7, 1'b0);
    consume("no_write", 0, 7'd13, 0);
    idle(8);

    // Flush kills stage-3 entry only: r7 dies, r8 survives.
    issue(7'd8, 4'd7);
    issue(7'd7, 4'd7);
    flush = 1;
    tick();
    flush = 0;
    consume("flush3_r7", 0, 7'd7, 0);
    consume("flush3_r8", 0, 7'd8, 2);
    check("flush3_count", stall_cycles, 16);
    idle(8);

    // Flush with flush_4stage: both producers die.
    issue(7'd8, 4'd7);
    issue(7'd7, 4'd7);
    flush = 1; flush_4stage = 1;
    @(negedge clk);
    check("flush4_before", inflight_count, 2);
    tick();
    flush = 0; flush_4stage = 0;
    @(negedge clk);
    check("flush4_after", inflight_count, 0);
    consume("flush4_r7", 0, 7'd7, 0);
    consume("flush4_r8", 0, 7'd8, 0);
    idle(8);

    // Drain: request raised with the third issue; issue_valid held after.
    issue(7'd1, 4'd2);
    issue(7'd2, 4'd2);
    issue_valid = 1; issue_reg_dst = 7'd3; issue_reg_wr = 1; issue_latency = 2;
    drain_req = 1;
    tick();
    issue_reg_dst = 7'd20;
    n = 0; done = 0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      check("drain_ready", issue_ready, 0);
      check("drain_count", stall_cycles, 16);
      if (drained) done = 1;
      else begin n++; tick(); end
    end
    check("drain_done", done, 1);
    check("drain_latency", n, 6);
    check("drain_empty", inflight_count, 0);
    tick();
    drain_req = 0;
    @(negedge clk);
    check("undrain_wait", issue_ready, 0);
    tick();
    @(negedge clk);
    check("undrain_fire", issue_fire, 1);
    check("undrain_flag", drained, 0);
    check("undrain_count", stall_cycles, 16);
    tick();
    issue_valid = 0;
    idle(8);

    // Reset mid-stall with four slots valid and stall_cycles = 10.
    rst = 1;
    tick();
    rst = 0;
    issue(7'd40, 4'd7);
    consume("pre_a", 0, 7'd40, 5);
    issue(7'd41, 4'd6);
    consume("pre_b", 1, 7'd41, 4);
    idle(8);
    issue(7'd1, 4'd2);
    issue(7'd2, 4'd2);
    issue(7'd3, 4'd2);
    issue(7'd4, 4'd7);
    issue_reg_wr = 0; ra_addr = 7'd4; ra_use = 1; issue_valid = 1;
    @(negedge clk);
    check("rst_mid_stall", stall_raw, 1);
    tick();
    rst = 1;
    @(negedge clk);
    check("rst_mid_inflight", inflight_count, 4);
    check("rst_mid_count", stall_cycles, 10);
    tick();
    rst = 0;
    @(negedge clk);
    check("rst_after_inflight", inflight_count, 0);
    check("rst_after_count", stall_cycles, 0);
    check("rst_after_stall", stall_raw, 0);
    check("rst_after_ready", issue_ready, 1);
    tick();
    clear_inputs();
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
